// File: rtl/uart2wifi_pkg.sv
// Shared types and constants for the UART-to-WiFi bridge core.
package uart2wifi_pkg;

  // Link-direction FSM encoding; the status register exposes these two bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } state_t;

  // Register port address map.
  localparam logic [1:0] REG0       = 2'd0;
  localparam logic [1:0] REG1       = 2'd1;
  localparam logic [1:0] REG2       = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Clocks per baud tick and register width used when not overridden.
  localparam int DEFAULT_BAUD_DIV = 10;
  localparam int DEFAULT_DATA_W   = 32;

endpackage

// File: rtl/uart2wifi_core_if.sv
// Register access port between the bus master and the bridge core.
interface uart2wifi_core_if #(
  parameter int DATA_W = 32
);

  logic [1:0]        reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_write;
  logic              reg_read;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_write,
    output reg_read,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_write,
    input  reg_read,
    output reg_rdata
  );

endinterface

// File: rtl/uart2wifi_core_baudtick.sv
// Baud-rate tick generator: one registered pulse every BAUD_DIV clocks.
module uart2wifi_core_baudtick
  import uart2wifi_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic baudtick
);

  localparam int              CNT_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Advance the counter and raise the tick on the cycle the counter wraps.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
    end
  end

  // Counter and tick flops; reset restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baudtick = tick_q;

endmodule

// File: rtl/uart2wifi_core.sv
// Bridge core: baud tick generator, three R/W registers plus status, and the
// link-direction FSM that drives the board LED.
module uart2wifi_core
  import uart2wifi_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   switch_in,
  input  logic                   data_in_test,
  input  logic                   data_out_test,
  uart2wifi_core_if.slave        bus,
  output logic                   baudtick,
  output logic                   board_led0
);

  state_t            state_q;
  state_t            state_d;
  logic              led_q;
  logic              led_d;
  logic [DATA_W-1:0] regs_q [3];
  logic [DATA_W-1:0] regs_d [3];
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] rdata_s;

  uart2wifi_core_baudtick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baudtick (
    .clk      (clk),
    .rst      (rst),
    .baudtick (baudtick)
  );

  // FSM state register, LED flop and register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      for (int i = 0; i < 3; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Next state: receive request wins over transmit request, else idle.
  always_comb begin
    state_d = IDLE;
    if (data_in_test) begin
      state_d = RX;
    end else if (data_out_test) begin
      state_d = TX;
    end else begin
      state_d = IDLE;
    end
  end

  // FSM outputs: LED lights for the switch or any active link direction.
  always_comb begin
    led_d    = switch_in | (state_q != IDLE);
    status_s = {{(DATA_W-2){1'b0}}, state_q};
  end

  // Register write path; writes to the status address are dropped.
  always_comb begin
    regs_d = regs_q;
    if (bus.reg_write) begin
      case (bus.reg_addr)
        REG0:    regs_d[0] = bus.reg_wdata;
        REG1:    regs_d[1] = bus.reg_wdata;
        REG2:    regs_d[2] = bus.reg_wdata;
        default: regs_d    = regs_q;
      endcase
    end else begin
      regs_d = regs_q;
    end
  end

  // Combinational read mux; returns zero when no read is requested.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    if (bus.reg_read) begin
      case (bus.reg_addr)
        REG0:       rdata_s = regs_q[0];
        REG1:       rdata_s = regs_q[1];
        REG2:       rdata_s = regs_q[2];
        REG_STATUS: rdata_s = status_s;
        default:    rdata_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end
  end

  assign bus.reg_rdata = rdata_s;
  assign board_led0    = led_q;

endmodule

// File: tb/tb_uart2wifi_core.sv
// Scoreboard bench for uart2wifi_core: stimulus queues expected reads/LED
// values, negedge monitors compare them and track the baud tick timing.
module tb_uart2wifi_core;

  logic clk           = 1'b0;
  logic rst           = 1'b1;
  logic switch_in     = 1'b0;
  logic data_in_test  = 1'b0;
  logic data_out_test = 1'b0;
  logic baudtick;
  logic board_led0;

  uart2wifi_core_if #(.DATA_W(32)) bus ();

  uart2wifi_core #(
    .BAUD_DIV (10),
    .DATA_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .switch_in     (switch_in),
    .data_in_test  (data_in_test),
    .data_out_test (data_out_test),
    .bus           (bus),
    .baudtick      (baudtick),
    .board_led0    (board_led0)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        led_q [$];
  logic        chk_led = 1'b0;
  logic [31:0] model [3];

  // ---------------- read / LED monitor ----------------
  logic [31:0] mon_e;
  string       mon_n;
  logic        mon_l;

  always @(negedge clk) begin
    if (bus.reg_read === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got %h, no expected value queued", bus.reg_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (bus.reg_rdata !== mon_e) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", mon_n, bus.reg_rdata, mon_e);
        end
      end
    end
    if (chk_led) begin
      n_vec++;
      if (led_q.size() == 0) begin
        n_err++;
        $display("FAIL led_unexpected: got %b, no expected value queued", board_led0);
      end else begin
        mon_l = led_q.pop_front();
        if (board_led0 !== mon_l) begin
          n_err++;
          $display("FAIL led: got %b, expected %b at %0t", board_led0, mon_l, $time);
        end
      end
    end
  end

  // ---------------- baud tick monitor ----------------
  logic rst_seen  = 1'b0;
  logic prev_tick = 1'b0;
  logic seen_rise = 1'b0;
  int   cyc_cnt   = 0;
  int   last_rise = 0;
  int   high_len  = 0;

  always @(posedge clk) begin
    if (rst) rst_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      rst_seen  = 1'b0;
      cyc_cnt   = 0;
      prev_tick = 1'b0;
      seen_rise = 1'b0;
      high_len  = 0;
    end else begin
      cyc_cnt++;
      if (baudtick === 1'b1) begin
        if (!prev_tick) begin
          n_vec++;
          if (!seen_rise) begin
            if (cyc_cnt != 10) begin
              n_err++;
              $display("FAIL baud_first: rose on edge %0d after reset, expected 10", cyc_cnt);
            end
          end else if (cyc_cnt - last_rise != 10) begin
            n_err++;
            $display("FAIL baud_period: got %0d clocks, expected 10", cyc_cnt - last_rise);
          end
          seen_rise = 1'b1;
          last_rise = cyc_cnt;
          high_len  = 1;
        end else begin
          high_len++;
        end
        prev_tick = 1'b1;
      end else begin
        if (prev_tick) begin
          n_vec++;
          if (high_len != 1) begin
            n_err++;
            $display("FAIL baud_width: high for %0d cycles, expected 1", high_len);
          end
        end
        prev_tick = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    cyc(1);
    bus.reg_write = 1'b0;
    case (a)
      2'd0:    model[0] = d;
      2'd1:    model[1] = d;
      2'd2:    model[2] = d;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus.reg_addr = a;
    bus.reg_read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc(1);
    bus.reg_read = 1'b0;
  endtask

  task automatic led(input logic e);
    led_q.push_back(e);
    chk_led = 1'b1;
    cyc(1);
    chk_led = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rv;

  initial begin
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 32'h0;
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    for (int i = 0; i < 3; i++) model[i] = 32'h0;

    cyc(3);
    rst = 1'b0;

    // reset state
    rd(2'd0, 32'h0, "rst_reg0");
    rd(2'd1, 32'h0, "rst_reg1");
    rd(2'd2, 32'h0, "rst_reg2");
    rd(2'd3, 32'h0, "rst_status");
    led(1'b0);

    // directed write / read-back
    wr(2'd0, 32'hDEADBEEF); rd(2'd0, 32'hDEADBEEF, "wr_reg0");
    wr(2'd1, 32'h12345678); rd(2'd1, 32'h12345678, "wr_reg1");
    wr(2'd2, 32'hA5A5A5A5); rd(2'd2, 32'hA5A5A5A5, "wr_reg2");

    // second pass with random data
    for (int i = 0; i < 3; i++) begin
      rv = $urandom;
      wr(2'(i), rv);
      rd(2'(i), rv, "rand_reg");
    end

    // read and write of the same register in one cycle returns the old value
    bus.reg_addr  = 2'd1;
    bus.reg_wdata = 32'h0BADCAFE;
    bus.reg_write = 1'b1;
    bus.reg_read  = 1'b1;
    exp_q.push_back(model[1]);
    name_q.push_back("rw_old");
    cyc(1);
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    model[1] = 32'h0BADCAFE;
    rd(2'd1, 32'h0BADCAFE, "rw_new");

    // status writes are ignored
    wr(2'd3, 32'hFFFFFFFF);
    rd(2'd0, model[0], "st_wr_reg0");
    rd(2'd1, model[1], "st_wr_reg1");
    rd(2'd2, model[2], "st_wr_reg2");
    rd(2'd3, 32'h0, "st_wr_status");

    // FSM walk: RX, TX, back to IDLE
    data_in_test = 1'b1;
    cyc(4);
    rd(2'd3, 32'h1, "fsm_rx");
    led(1'b1);
    data_in_test  = 1'b0;
    data_out_test = 1'b1;
    cyc(5);
    rd(2'd3, 32'h2, "fsm_tx");
    led(1'b1);
    data_out_test = 1'b0;
    cyc(2);
    rd(2'd3, 32'h0, "fsm_idle");
    led(1'b0);
    switch_in = 1'b1;
    cyc(1);
    led(1'b1);
    switch_in = 1'b0;
    cyc(1);
    led(1'b0);

    // priority: both strobes select RX
    data_in_test  = 1'b1;
    data_out_test = 1'b1;
    cyc(1);
    rd(2'd3, 32'h1, "fsm_prio");
    led(1'b1);
    data_in_test  = 1'b0;
    data_out_test = 1'b0;
    cyc(2);

    // reset mid-run overrides a write and a TX request
    wr(2'd0, 32'h11111111);
    wr(2'd2, 32'h22222222);
    data_out_test = 1'b1;
    cyc(2);
    rd(2'd3, 32'h2, "pre_rst_tx");
    rst           = 1'b1;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 32'hCAFEF00D;
    bus.reg_write = 1'b1;
    cyc(1);
    rst           = 1'b0;
    bus.reg_write = 1'b0;
    data_out_test = 1'b0;
    led(1'b0);
    rd(2'd0, 32'h0, "mrst_reg0");
    rd(2'd1, 32'h0, "mrst_reg1");
    rd(2'd2, 32'h0, "mrst_reg2");
    rd(2'd3, 32'h0, "mrst_status");

    // let the baud monitor see the restarted period
    cyc(25);

    n_vec++;
    if (exp_q.size() != 0 || led_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d reads and %0d LED checks left, expected 0", exp_q.size(), led_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
